// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the RV32I execute unit: datapath sizing, the
//   alu_op encodings, the one-hot FSM state encoding, the shift direction
//   type, the registered flag bundle, and the is_shift() helper.
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;
  localparam int ALU_OP_W    = 5;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 5'b00001;
  localparam alu_op_t OP_SUB  = 5'b00011;
  localparam alu_op_t OP_AGEN = 5'b11000;
  localparam alu_op_t OP_AND  = 5'b01010;
  localparam alu_op_t OP_OR   = 5'b01100;
  localparam alu_op_t OP_XOR  = 5'b01101;
  localparam alu_op_t OP_SLT  = 5'b00100;
  localparam alu_op_t OP_SLTU = 5'b00101;
  localparam alu_op_t OP_SLL  = 5'b01110;
  localparam alu_op_t OP_SRL  = 5'b01111;
  localparam alu_op_t OP_SRA  = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_EXEC  = 5'b00010,
    ST_SHIFT = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_DRAIN = 5'b10000
  } alu_state_e;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  // Flags are always written together with the result.
  typedef struct packed {
    logic zero;
    logic lt;
    logic ltu;
    logic illegal;
  } alu_flags_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// ----------------------------------------------------------------------------
// alu_exec_unit_if
//   Controller <-> execute-unit handshake bundle.
//   master (controller): drives alu_en, alu_op, operand_a, operand_b;
//                        receives alu_valid, alu_result and the flags.
//   slave  (execute unit): the mirror image.
//   alu_en is a level held until alu_valid is seen; alu_valid is a
//   one-cycle pulse; result and flags hold until the next operation.
// ----------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             alu_en;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_lt;
  logic             alu_ltu;
  logic             alu_illegal;

  modport master (
    output alu_en, alu_op, operand_a, operand_b,
    input  alu_valid, alu_result, alu_zero, alu_lt, alu_ltu, alu_illegal
  );

  modport slave (
    input  alu_en, alu_op, operand_a, operand_b,
    output alu_valid, alu_result, alu_zero, alu_lt, alu_ltu, alu_illegal
  );

endinterface

// File: rtl/alu_shift_iter.sv
// ----------------------------------------------------------------------------
// alu_shift_iter
//   Iterative one-bit-per-cycle shifter.
//   load     : capture data_in, shamt, dir, arith (takes priority)
//   dir      : SHIFT_LEFT (zero fill) or SHIFT_RIGHT
//   arith    : right shifts replicate the sign bit instead of zero fill
//   shamt    : number of single-bit steps still to perform
//   data_in  : value to shift
//   busy     : steps remain (counter non-zero)
//   data_out : current shift register contents
// ----------------------------------------------------------------------------
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  shift_dir_e         dir,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  shift_dir_e         dir_q, dir_d;
  logic               arith_q, arith_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; that is what keeps this block latch-free.
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (load) begin
      data_d  = data_in;
      cnt_d   = shamt;
      dir_d   = dir;
      arith_d = arith;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SHAMT_W'(1);
      if (dir_q == SHIFT_LEFT) begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
        data_d = {(arith_q ? data_q[WIDTH-1] : 1'b0), data_q[WIDTH-1:1]};
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: these are plain registers (not a memory array), so all of them
  // are reset; the shift register clears to 0 along with the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= SHIFT_LEFT;
      arith_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign data_out = data_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
//   Multi-cycle RV32I execute unit, responder side of alu_en/alu_valid.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : alu_exec_unit_if.slave
//                alu_en/alu_op/operand_a/operand_b in; alu_valid (1-cycle
//                pulse), alu_result, alu_zero, alu_lt, alu_ltu, alu_illegal out.
//   Single-cycle ops finish one cycle after the start; shifts with a
//   non-zero amount run through alu_shift_iter, one bit per cycle.
// ----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);

  alu_state_e       state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  logic               shift_start;
  logic               shift_busy;
  logic [WIDTH-1:0]   shift_out;
  logic [SHAMT_W-1:0] start_shamt;
  shift_dir_e         start_dir;

  logic [WIDTH-1:0] exec_result;
  logic             exec_illegal;
  logic             lt_s;
  logic             ltu_s;

  // Only the low bits of operand_b form the shift amount.
  assign start_shamt = bus.operand_b[SHAMT_W-1:0];
  assign start_dir   = (bus.alu_op == OP_SLL) ? SHIFT_LEFT : SHIFT_RIGHT;
  // A zero-amount shift is just a pass-through and takes the EXEC path.
  assign shift_start = (state_q == ST_IDLE) && bus.alu_en &&
                       is_shift(bus.alu_op) && (start_shamt != '0);

  alu_shift_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (shift_start),
    .dir      (start_dir),
    .arith    (bus.alu_op == OP_SRA),
    .shamt    (start_shamt),
    .data_in  (bus.operand_a),
    .busy     (shift_busy),
    .data_out (shift_out)
  );

  // Single-cycle ALU on the latched operands. Compare flags are produced
  // for every op so branches can use them.
  always_comb begin
    lt_s         = $signed(a_q) < $signed(b_q);
    ltu_s        = a_q < b_q;
    exec_result  = '0;
    exec_illegal = 1'b0;
    case (op_q)
      OP_ADD, OP_AGEN:        exec_result = a_q + b_q;
      OP_SUB:                 exec_result = a_q - b_q;
      OP_AND:                 exec_result = a_q & b_q;
      OP_OR:                  exec_result = a_q | b_q;
      OP_XOR:                 exec_result = a_q ^ b_q;
      OP_SLT:                 exec_result = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU:                exec_result = {{(WIDTH-1){1'b0}}, ltu_s};
      // Shifts only reach EXEC with a zero amount.
      OP_SLL, OP_SRL, OP_SRA: exec_result = a_q;
      default:                exec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.alu_en) begin
          op_d    = bus.alu_op;
          a_d     = bus.operand_a;
          b_d     = bus.operand_b;
          state_d = shift_start ? ST_SHIFT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Dropping alu_en aborts without touching the outputs.
        if (!bus.alu_en) begin
          state_d = ST_IDLE;
        end else begin
          result_d        = exec_result;
          flags_d.zero    = (exec_result == '0);
          flags_d.lt      = lt_s;
          flags_d.ltu     = ltu_s;
          flags_d.illegal = exec_illegal;
          state_d         = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (!bus.alu_en) begin
          state_d = ST_IDLE;
        end else if (!shift_busy) begin
          result_d        = shift_out;
          flags_d.zero    = (shift_out == '0);
          flags_d.lt      = lt_s;
          flags_d.ltu     = ltu_s;
          flags_d.illegal = 1'b0;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DRAIN;
      // The alu_en level that produced the pulse must go away before a
      // new start can be taken.
      ST_DRAIN: begin
        if (!bus.alu_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.alu_valid   = (state_q == ST_DONE);
  assign bus.alu_result  = result_q;
  assign bus.alu_zero    = flags_q.zero;
  assign bus.alu_lt      = flags_q.lt;
  assign bus.alu_ltu     = flags_q.ltu;
  assign bus.alu_illegal = flags_q.illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed cases with literal expectations, then randomized traffic, all
//   compared every cycle against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pulses   = 0;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(
    .WIDTH   (W),
    .SHAMT_W (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of one operation.
  function automatic void ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill);
    r   = '0;
    ill = 1'b0;
    case (op)
      OP_ADD, OP_AGEN: r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      default: ill = 1'b1;
    endcase
  endfunction

  // Transaction model: an accepted request completes after a fixed number
  // of edges (1, or shamt+1 for real shifts) unless alu_en drops first.
  bit          m_busy, m_pulse, m_wait_drop;
  int          m_left;
  logic [31:0] p_res, m_res;
  logic        p_ill, p_lt, p_ltu;
  logic        m_zero, m_lt, m_ltu, m_ill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_pulse = 0; m_wait_drop = 0; m_left = 0;
      m_res = '0; m_zero = 0; m_lt = 0; m_ltu = 0; m_ill = 0;
    end else if (m_pulse) begin
      m_pulse     = 0;
      m_wait_drop = 1;
    end else if (m_wait_drop) begin
      if (!bus.alu_en) m_wait_drop = 0;
    end else if (m_busy) begin
      if (!bus.alu_en) begin
        m_busy = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_pulse = 1;
          m_res = p_res; m_zero = (p_res == 0); m_lt = p_lt; m_ltu = p_ltu; m_ill = p_ill;
        end
      end
    end else if (bus.alu_en) begin
      ref_alu(bus.alu_op, bus.operand_a, bus.operand_b, p_res, p_ill);
      p_lt   = $signed(bus.operand_a) < $signed(bus.operand_b);
      p_ltu  = bus.operand_a < bus.operand_b;
      m_left = (is_shift(bus.alu_op) && bus.operand_b[4:0] != 0) ? int'(bus.operand_b[4:0]) + 1 : 1;
      m_busy = 1;
    end
  end

  always @(negedge clk) begin
    if (bus.alu_valid) pulses++;
    check("valid", 64'(bus.alu_valid), 64'(m_pulse));
    check("result", 64'(bus.alu_result), 64'(m_res));
    check("flags", 64'({bus.alu_zero, bus.alu_lt, bus.alu_ltu, bus.alu_illegal}),
          64'({m_zero, m_lt, m_ltu, m_ill}));
  end

  // Issue one request, wait for the pulse, optionally hold alu_en longer,
  // then release. lat counts edges from the accepting edge to the edge that
  // first samples alu_valid high.
  task automatic do_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit jitter, output int lat);
    int start_cyc;
    bit got;
    @(posedge clk); #1;
    bus.alu_en = 1'b1; bus.alu_op = op; bus.operand_a = a; bus.operand_b = b;
    start_cyc = cyc + 1;
    got = 0;
    lat = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus.alu_valid) begin
        got = 1;
        lat = cyc + 1 - start_cyc;
      end else if (jitter && i > 0) begin
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.alu_op    = alu_op_t'($urandom_range(0, 31));
      end
    end
    check("valid_seen", 64'(got), 64'(1));
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.alu_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue a request and drop alu_en after k further edges.
  task automatic drop_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input int k);
    @(posedge clk); #1;
    bus.alu_en = 1'b1; bus.alu_op = op; bus.operand_a = a; bus.operand_b = b;
    repeat (k + 1) @(posedge clk);
    #1 bus.alu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  alu_op_t ops [13] = '{OP_ADD, OP_SUB, OP_AGEN, OP_AND, OP_OR, OP_XOR, OP_SLT,
                        OP_SLTU, OP_SLL, OP_SRL, OP_SRA, 5'b00000, 5'b11111};

  initial begin
    int          lat;
    int          p0;
    alu_op_t     op;
    logic [31:0] a, b;
    int          sel;

    bus.alu_en = 1'b0; bus.alu_op = '0; bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", 64'({bus.alu_valid, bus.alu_result, bus.alu_zero, bus.alu_lt,
                                 bus.alu_ltu, bus.alu_illegal}), 64'(0));
    rst_n = 1'b1;

    // ADD / SUB / AGEN
    do_op(OP_ADD, 32'd7, 32'd5, 0, 0, lat);
    check("add_result", 64'(bus.alu_result), 64'(12));
    check("add_latency", 64'(lat), 64'(2));
    do_op(OP_SUB, 32'd5, 32'd7, 0, 0, lat);
    check("sub_result", 64'(bus.alu_result), 64'h0000_0000_FFFF_FFFE);
    do_op(OP_AGEN, 32'h0000_1000, 32'hFFFF_FFFC, 0, 0, lat);
    check("agen_result", 64'(bus.alu_result), 64'h0FFC);

    // Shifts: multi-cycle, zero amount, maximum amount with ignored upper bits
    do_op(OP_SRA, 32'h8000_0000, 32'd4, 0, 0, lat);
    check("sra_result", 64'(bus.alu_result), 64'h0000_0000_F800_0000);
    check("sra_latency", 64'(lat), 64'(6));
    do_op(OP_SLL, 32'h0000_1234, 32'h0000_0020, 0, 0, lat);
    check("sll0_result", 64'(bus.alu_result), 64'h1234);
    check("sll0_latency", 64'(lat), 64'(2));
    do_op(OP_SRL, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat);
    check("srl31_result", 64'(bus.alu_result), 64'(1));
    check("srl31_latency", 64'(lat), 64'(33));

    // Compares and zero flag
    do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 0, lat);
    check("slt_result", 64'(bus.alu_result), 64'(1));
    check("slt_flags", 64'({bus.alu_lt, bus.alu_ltu}), 64'(2'b10));
    do_op(OP_XOR, 32'h0000_A5A5, 32'h0000_A5A5, 0, 0, lat);
    check("xor_result", 64'(bus.alu_result), 64'(0));
    check("xor_zero", 64'(bus.alu_zero), 64'(1));

    // alu_en held past the pulse: one pulse only; the next request is taken
    p0 = pulses;
    do_op(OP_ADD, 32'd3, 32'd4, 5, 0, lat);
    check("hold_one_pulse", 64'(pulses - p0), 64'(1));
    do_op(OP_OR, 32'h0000_00F0, 32'h0000_000F, 0, 0, lat);
    check("second_op_result", 64'(bus.alu_result), 64'hFF);

    // Abort in the middle of a shift
    p0 = pulses;
    drop_op(OP_SRL, 32'hFFFF_0000, 32'd20, 5);
    check("abort_no_pulse", 64'(pulses - p0), 64'(0));
    check("abort_result_held", 64'(bus.alu_result), 64'hFF);

    // Unknown op code
    do_op(5'b11111, 32'd9, 32'd9, 0, 0, lat);
    check("illegal_result", 64'(bus.alu_result), 64'(0));
    check("illegal_flag", 64'(bus.alu_illegal), 64'(1));

    // Reset in the middle of a shift
    do_op(OP_ADD, 32'd1, 32'd2, 0, 0, lat);
    check("pre_reset_result", 64'(bus.alu_result), 64'(3));
    @(posedge clk); #1;
    bus.alu_en = 1'b1; bus.alu_op = OP_SLL; bus.operand_a = 32'd1; bus.operand_b = 32'd10;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0; bus.alu_en = 1'b0;
    #1 check("reset_mid_shift", 64'({bus.alu_valid, bus.alu_result, bus.alu_zero, bus.alu_lt,
                                     bus.alu_ltu, bus.alu_illegal}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    p0 = pulses;
    repeat (20) @(posedge clk);
    #1 check("no_pulse_after_reset", 64'(pulses - p0), 64'(0));

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      op  = ops[$urandom_range(0, 12)];
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = a;
      else if (sel == 1) a = '0;
      else if (sel == 2) b = a + 32'd1;
      if (is_shift(op) && $urandom_range(0, 3) != 0) b = (b & ~32'h1F) | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) drop_op(op, a, b, $urandom_range(0, 10));
      else do_op(op, a, b, $urandom_range(0, 3), 1'b1, lat);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
